// File: rtl/dmx_processor_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_processor_writer_pkg
//  Description : Shared definitions for the DMX512 processor writer:
//                writer state encoding, slot count, start code and the
//                slot-bit helper used by the serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmx_processor_writer_pkg;

    localparam int unsigned c_slot_count    = 512;
    localparam int unsigned c_addr_w        = 9;
    localparam int unsigned c_bits_per_slot = 11;
    localparam logic [7:0]  c_start_code    = 8'h00;
    localparam logic [8:0]  c_last_slot     = 9'(c_slot_count - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAB   = 2'd2,
        ST_SLOT  = 2'd3
    } writer_state_t;

    // Line level for bit position idx of an 11-bit slot frame:
    // 0 = start bit, 1..8 = data LSB first, 9..10 = stop bits.
    function automatic logic slot_bit(input logic [7:0] data, input logic [3:0] idx);
        logic v;
        v = 1'b1;
        if (idx == 4'd0) begin
            v = 1'b0;
        end else if (idx <= 4'd8) begin
            v = data[3'(idx - 4'd1)];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmx_processor_writer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_writer
//  Description : DMX512 frame generator: IDLE/BREAK/MAB/SLOT state machine,
//                11-bit slot serializer and slot-data request generator.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                o_request_pulse    - one-cycle read request to the store
//                o_request_addr     - slot number being requested
//                i_data, i_addr     - store reply (data + echoed address),
//                                     valid one cycle after the request
//                o_dmx              - serial line, 1 = mark/idle
//  Revision    : 1.0 - initial release
// ============================================================================
module dmx_writer
    import dmx_processor_writer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 108,
    parameter int BREAK_BITS   = 25,
    parameter int MAB_BITS     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       o_request_pulse,
    output logic [8:0] o_request_addr,
    input  logic [7:0] i_data,
    input  logic [8:0] i_addr,
    output logic       o_dmx
);

    localparam int unsigned c_bit_cycles   = CLKS_PER_BIT;
    localparam int unsigned c_break_cycles = BREAK_BITS * CLKS_PER_BIT;
    localparam int unsigned c_mab_cycles   = MAB_BITS * CLKS_PER_BIT;
    localparam int unsigned c_longest      =
        (c_break_cycles > c_mab_cycles) ?
            ((c_break_cycles > c_bit_cycles) ? c_break_cycles : c_bit_cycles) :
            ((c_mab_cycles > c_bit_cycles) ? c_mab_cycles : c_bit_cycles);
    localparam int unsigned c_cnt_w        = $clog2(c_longest + 1);

    localparam logic [c_cnt_w-1:0] c_bit_last   = c_cnt_w'(c_bit_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_break_last = c_cnt_w'(c_break_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_mab_last   = c_cnt_w'(c_mab_cycles - 1);
    localparam logic [3:0]         c_stop2_idx  = 4'(c_bits_per_slot - 1);

    writer_state_t        r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_bit_idx;
    logic [8:0]           r_slot;
    logic [7:0]           r_byte;
    logic                 r_req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_slot          <= '0;
            r_byte          <= '0;
            r_req_d         <= 1'b0;
            o_request_pulse <= 1'b0;
            o_request_addr  <= '0;
            o_dmx           <= 1'b1;
        end else begin
            o_request_pulse <= 1'b0;
            r_req_d         <= o_request_pulse;

            // Store reply arrives one cycle after the request; the echoed
            // address guards against latching a stale reply.
            if (r_req_d && (i_addr == o_request_addr)) begin
                r_byte <= i_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_BREAK;
                        o_dmx   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    if (r_cnt == c_break_last) begin
                        r_cnt           <= '0;
                        r_state         <= ST_MAB;
                        o_dmx           <= 1'b1;
                        // Slot 0 is fetched during MAB so it is ready at
                        // the first start bit.
                        o_request_pulse <= 1'b1;
                        o_request_addr  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_MAB: begin
                    if (r_cnt == c_mab_last) begin
                        r_cnt     <= '0;
                        r_state   <= ST_SLOT;
                        r_slot    <= '0;
                        r_bit_idx <= '0;
                        o_dmx     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SLOT: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (r_bit_idx == c_stop2_idx) begin
                            r_bit_idx <= '0;
                            o_dmx     <= 1'b0;
                            if (r_slot == c_last_slot) begin
                                r_state <= ST_BREAK;
                            end else begin
                                r_slot <= r_slot + 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            o_dmx     <= slot_bit(r_byte, r_bit_idx + 4'd1);
                            // Entering the first stop bit: the data bits are
                            // done, so the next slot's byte may replace r_byte.
                            if ((r_bit_idx == 4'd8) && (r_slot != c_last_slot)) begin
                                o_request_pulse <= 1'b1;
                                o_request_addr  <= r_slot + 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    o_dmx   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmx_processor_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_processor_writer
//  Description : DMX512 transmitter with a 512-slot channel store. Pan/tilt
//                values are written into the store on calc_ready; the
//                dmx_writer streams the store out as continuous frames.
//  Ports       : clk         - clock (rising edge)
//                reset       - async active-low reset
//                pan_addr    - slot receiving pan
//                tilt_addr   - slot receiving tilt
//                pan, tilt   - values to store
//                calc_ready  - one-cycle strobe, inputs valid
//                dmx_out     - serial DMX512 line, 1 = mark/idle
//  Revision    : 1.0 - initial release
// ============================================================================
module dmx_processor_writer
    import dmx_processor_writer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 108,
    parameter int BREAK_BITS   = 25,
    parameter int MAB_BITS     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] pan_addr,
    input  logic [8:0] tilt_addr,
    input  logic [7:0] pan,
    input  logic [7:0] tilt,
    input  logic       calc_ready,
    output logic       dmx_out
);

    logic [7:0] r_mem [0:c_slot_count-1];
    logic [7:0] r_data_out;
    logic [8:0] r_addr_out;
    logic       w_request_pulse;
    logic [8:0] w_request_addr;
    logic       w_dmx;

    // Channel store. Entry 0 is never written, reads of slot 0 return the
    // start code. Reads sample the array before this edge's writes land,
    // so a simultaneous read/write of one slot yields the old byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_slot_count; i++) begin
                r_mem[i] <= '0;
            end
            r_data_out <= '0;
            r_addr_out <= '0;
        end else begin
            if (calc_ready) begin
                // Pan wins a shared address by skipping the tilt write.
                if ((tilt_addr != 9'd0) && (tilt_addr != pan_addr)) begin
                    r_mem[tilt_addr] <= tilt;
                end
                if (pan_addr != 9'd0) begin
                    r_mem[pan_addr] <= pan;
                end
            end
            if (w_request_pulse) begin
                r_addr_out <= w_request_addr;
                r_data_out <= (w_request_addr == 9'd0) ? c_start_code
                                                       : r_mem[w_request_addr];
            end
        end
    end

    dmx_writer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .BREAK_BITS   (BREAK_BITS),
        .MAB_BITS     (MAB_BITS)
    ) u_writer (
        .clk             (clk),
        .rst_n           (reset),
        .o_request_pulse (w_request_pulse),
        .o_request_addr  (w_request_addr),
        .i_data          (r_data_out),
        .i_addr          (r_addr_out),
        .o_dmx           (w_dmx)
    );

    assign dmx_out = w_dmx;

endmodule
`default_nettype wire

// File: tb/tb_dmx_processor_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmx_processor_writer
//  Description : Self-checking bench for dmx_processor_writer. A timeline
//                model predicts the line level on every cycle from the frame
//                arithmetic and a copy of the channel store; pinned literal
//                values anchor the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmx_processor_writer;

    localparam int CPB      = 4;
    localparam int BRK      = 25 * CPB;           // 100 cycles
    localparam int MABC     = 3 * CPB;            // 12 cycles
    localparam int SLOTC    = 11 * CPB;           // 44 cycles
    localparam int FRAME    = BRK + MABC + 512 * SLOTC;
    localparam int IDLEC    = CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] pan_addr = '0;
    logic [8:0] tilt_addr = '0;
    logic [7:0] pan = '0;
    logic [7:0] tilt = '0;
    logic       calc_ready = 1'b0;
    logic       dmx_out;

    dmx_processor_writer #(
        .CLKS_PER_BIT (CPB),
        .BREAK_BITS   (25),
        .MAB_BITS     (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pan_addr   (pan_addr),
        .tilt_addr  (tilt_addr),
        .pan        (pan),
        .tilt       (tilt),
        .calc_ready (calc_ready),
        .dmx_out    (dmx_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mstore  [512];   // model of the channel store
    logic [7:0]  snap    [512];   // byte each slot will carry this frame
    logic [7:0]  cur_dec [512];   // bytes decoded from dmx_out
    logic [10:0] cur_raw0;
    logic [10:0] cur_raw1;
    int          t;               // cycles since reset release
    bit          in_reset;
    bit          directed_en;
    bit          pin_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 512; i++) begin
            mstore[i] = 8'h00;
            snap[i]   = 8'h00;
        end
    endtask

    // Writes are kept away from MAB and from the request window around the
    // first stop bit so the outcome does not hinge on the exact request cycle.
    function automatic bit write_ok(input int tt);
        int o, s, b;
        if (tt < IDLEC) return 1'b1;
        o = (tt - IDLEC) % FRAME;
        if (o >= BRK - 1 && o < BRK + MABC) return 1'b0;
        if (o < BRK) return 1'b1;
        s = o - BRK - MABC;
        b = (s % SLOTC) / CPB;
        return !(b == 8 || b == 9);
    endfunction

    task automatic step(input bit wr, input logic [8:0] pa, input logic [8:0] ta,
                        input logic [7:0] pv, input logic [7:0] tv);
        logic e;
        int   o, s, k, b, w;
        @(negedge clk);
        calc_ready = 1'b0;
        if (in_reset) begin
            chk("reset_dmx", 32'(dmx_out), 32'd1);
            chk("reset_req", 32'(dut.w_request_pulse), 32'd0);
        end else begin
            e = 1'b1;
            if (t >= IDLEC) begin
                o = (t - IDLEC) % FRAME;
                if (o < BRK) begin
                    e = 1'b0;
                end else if (o < BRK + MABC) begin
                    e = 1'b1;
                    if (o == BRK) snap[0] = 8'h00;
                end else begin
                    s = o - BRK - MABC;
                    k = s / SLOTC;
                    b = (s % SLOTC) / CPB;
                    w = s % CPB;
                    if (b == 0)      e = 1'b0;
                    else if (b <= 8) e = snap[k][b-1];
                    else             e = 1'b1;
                    if (b == 9 && w == 0 && k < 511) snap[k+1] = mstore[k+1];
                    if (w == 2) begin
                        if (b >= 1 && b <= 8) cur_dec[k][b-1] = dmx_out;
                        if (k == 0) cur_raw0[b] = dmx_out;
                        if (k == 1) cur_raw1[b] = dmx_out;
                    end
                end
            end
            chk("dmx_out", 32'(dmx_out), 32'(e));
            if (pin_en) begin
                case (t)
                    3:   chk("pin_idle_end",   32'(dmx_out), 32'd1);
                    4:   chk("pin_break_first", 32'(dmx_out), 32'd0);
                    103: chk("pin_break_last", 32'(dmx_out), 32'd0);
                    104: chk("pin_mab_first",  32'(dmx_out), 32'd1);
                    115: chk("pin_mab_last",   32'(dmx_out), 32'd1);
                    116: chk("pin_start_bit",  32'(dmx_out), 32'd0);
                    default: ;
                endcase
            end
        end
        if (wr && !in_reset) begin
            pan_addr   = pa;
            tilt_addr  = ta;
            pan        = pv;
            tilt       = tv;
            calc_ready = 1'b1;
            if (ta != 9'd0 && ta != pa) mstore[ta] = tv;
            if (pa != 9'd0)             mstore[pa] = pv;
        end
        if (!in_reset) t++;
    endtask

    task automatic run_until(input int tend, input bit rnd);
        bit         wr;
        logic [8:0] pa, ta;
        while (t < tend) begin
            if (directed_en && t == 10)
                step(1'b1, 9'd1, 9'd0, 8'd53, 8'd0);
            else if (directed_en && t == 5000)
                step(1'b1, 9'd4, 9'd2, 8'd170, 8'd242);
            else if (directed_en && t == 6020)
                step(1'b1, 9'd7, 9'd7, 8'd1, 8'd2);
            else if (directed_en && t == 6030)
                step(1'b1, 9'd0, 9'd0, 8'hFF, 8'h00);
            else begin
                wr = rnd && write_ok(t) && ($urandom_range(0, 39) == 0);
                pa = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(8, 511));
                ta = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(8, 511));
                if ($urandom_range(0, 3) == 0) ta = pa;
                step(wr, pa, ta, 8'($urandom), 8'($urandom));
            end
        end
    endtask

    task automatic release_reset();
        reset    = 1'b1;
        in_reset = 1'b0;
        t        = 1;   // the next sample follows the first active edge
    endtask

    initial begin
        int nz;
        clear_model();
        in_reset    = 1'b1;
        directed_en = 1'b0;
        pin_en      = 1'b0;
        t           = 0;
        cur_raw0    = '0;
        cur_raw1    = '0;

        repeat (100) step(1'b0, 9'd0, 9'd0, 8'd0, 8'd0);

        // Frame 1 with directed writes plus random traffic on slots >= 8
        release_reset();
        pin_en      = 1'b1;
        directed_en = 1'b1;
        run_until(IDLEC + FRAME, 1'b1);
        directed_en = 1'b0;
        pin_en      = 1'b0;
        chk("f1_slot0_bits", 32'(cur_raw0), 32'h600);
        chk("f1_slot1_bits", 32'(cur_raw1), 32'h66A);
        chk("f1_slot1",      32'(cur_dec[1]), 32'h35);
        chk("f1_slot2_late", 32'(cur_dec[2]), 32'h00);

        // Frame 2: all directed updates visible
        run_until(IDLEC + 2 * FRAME, 1'b1);
        chk("f2_slot0", 32'(cur_dec[0]), 32'h00);
        chk("f2_slot1", 32'(cur_dec[1]), 32'h35);
        chk("f2_slot2", 32'(cur_dec[2]), 32'hF2);
        chk("f2_slot3", 32'(cur_dec[3]), 32'h00);
        chk("f2_slot4", 32'(cur_dec[4]), 32'hAA);
        chk("f2_slot7", 32'(cur_dec[7]), 32'h01);
        chk("f2_slot1_bits", 32'(cur_raw1), 32'h66A);

        // Frame 3: abort in the middle of slot 3, data bit 3
        run_until(IDLEC + 2 * FRAME + BRK + MABC + 3 * SLOTC + 3 * CPB + 2, 1'b1);
        step(1'b0, 9'd0, 9'd0, 8'd0, 8'd0);
        chk("pre_abort_low", 32'(dmx_out), 32'd0);
        reset = 1'b0;
        #1;
        chk("async_reset", 32'(dmx_out), 32'd1);
        in_reset = 1'b1;
        clear_model();
        repeat (20) step(1'b0, 9'd0, 9'd0, 8'd0, 8'd0);

        // Fresh frame after the abort: everything back to zero
        release_reset();
        pin_en = 1'b1;
        run_until(IDLEC + FRAME, 1'b0);
        pin_en = 1'b0;
        nz = 0;
        for (int i = 0; i < 512; i++) if (cur_dec[i] !== 8'h00) nz++;
        chk("post_reset_nonzero_slots", 32'(nz), 32'd0);
        chk("post_reset_slot0_bits", 32'(cur_raw0), 32'h600);
        chk("post_reset_slot1_bits", 32'(cur_raw1), 32'h600);
        run_until(IDLEC + FRAME + 150, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog t=%0d actual=running required=finished", t);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmx_processor_writer.md
DMX_PROCESSOR_WRITER -- requirements
Module: dmx_processor_writer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 108, sets clocks per DMX bit; 27 MHz / 108 gives 250 kbaud.
REQ-002 Parameter BREAK_BITS, default 25, sets break length in bit times (100 us).
REQ-003 Parameter MAB_BITS, default 3, sets mark-after-break length in bit times (12 us).
REQ-004 Port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-006 Port pan_addr, input, 9 bits: DMX slot that receives pan.
REQ-007 Port tilt_addr, input, 9 bits: DMX slot that receives tilt.
REQ-008 Port pan, input, 8 bits: pan value.
REQ-009 Port tilt, input, 8 bits: tilt value.
REQ-010 Port calc_ready, input, 1 bit: one-cycle strobe marking pan, tilt and both addresses as valid.
REQ-011 Port dmx_out, output, 1 bit: serial DMX512 line (1 = mark/idle).

Function
REQ-012 The block SHALL hold a channel store of slots 1..511, each 8 bits wide; slot 0 is the start code, fixed at 0x00.
REQ-013 On a clk edge with calc_ready=1, the block SHALL write pan to slot pan_addr and tilt to slot tilt_addr.
REQ-014 Writes to address 0 SHALL be ignored.
REQ-015 If pan_addr==tilt_addr, pan SHALL win.
REQ-016 Stored values SHALL persist until overwritten or reset.
REQ-017 Internal request handshake between writer and store:
- The writer pulses request_pulse for one cycle with a 9-bit request_addr.
- The store returns data_out plus echoed addr_out, registered, exactly 1 cycle later.
- The writer latches that byte; it is held for the whole slot, so a slot never tears.
REQ-018 The writer FSM SHALL have states IDLE, BREAK, MAB and SLOT.
REQ-019 IDLE: dmx_out=1 for 1 bit time after reset release, then go to BREAK.
REQ-020 BREAK: dmx_out=0 for BREAK_BITS*CLKS_PER_BIT cycles, then go to MAB.
REQ-021 MAB: dmx_out=1 for MAB_BITS*CLKS_PER_BIT cycles, then go to SLOT with slot index 0.
REQ-022 SLOT: send 11 bits, each CLKS_PER_BIT cycles: start bit 0, then data bits LSB first, then two stop bits 1.
REQ-023 Slots SHALL be sent in the order 0,1,...,511, with no inter-slot gap.
REQ-024 After slot 511 completes, the writer SHALL return to BREAK, repeating frames forever.
REQ-025 The request for slot n+1 SHALL be issued during the first stop bit of slot n; the request for slot 0 SHALL be issued during MAB.
REQ-026 A store update takes effect from the next time that slot is requested; the current slot if already latched keeps its old byte.
REQ-027 The store write port and the request read port SHALL operate in the same cycle without conflict; a read of a slot being written returns the old value.

Reset
REQ-028 While reset=0, dmx_out SHALL be 1 asynchronously.
REQ-029 While reset=0, the FSM SHALL be held in IDLE with all counters at 0, request_pulse=0, and all store slots at 0x00.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; after release the next frame begins per REQ-019.

Structure
REQ-031 A shared package SHALL hold state encodings, the slot count 512 and the start code 0x00.
REQ-032 The design SHALL use one sub-module, dmx_writer, containing the FSM, the serializer and the request generator.
REQ-033 The channel store and the calc_ready write logic SHALL live in the top.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-034 Reset held low for 100 cycles -> dmx_out=1 throughout and no request pulses.
REQ-035 Reset release -> dmx_out: 1 for 4 cycles, then 0 for 100 cycles, then 1 for 12 cycles, then slot 0 as 0 followed by ten bits 0,0,0,0,0,0,0,0,1,1.
REQ-036 pan_addr=1, pan=53, one-cycle calc_ready -> next frame slot 1 bits are 0,1,0,1,0,1,1,0,0,1,1; all other slots are 0x00.
REQ-037 Then tilt_addr=2, tilt=242, pan_addr=4, pan=170, calc_ready pulse -> next frame slots 1..4 read 0x35, 0xF2, 0x00, 0xAA.
REQ-038 pan_addr=tilt_addr=7, pan=1, tilt=2 -> slot 7 = 0x01; a write with pan_addr=0, pan=0xFF -> start code stays 0x00.
REQ-039 Reset pulsed low mid-slot 3 -> dmx_out=1 without waiting for a clock edge; the next frame shows all slots at 0x00.
